ir_freq_classifier: RTL

IR_FREQ_CLASSIFIER -- requirements
Module: ir_freq_classifier

---
 rtl/ir_det_pkg.sv | 19 +
 rtl/ir_period_meter.sv | 56 +++++
 rtl/ir_freq_classifier.sv | 91 +++++++++
 3 files changed

// File: rtl/ir_det_pkg.sv
// Shared constants for the IR frequency detector: decision code width helper
// and default band limits (200/1000/5000/7000 Hz carriers at a 100 MHz clock).
package ir_det_pkg;

  localparam int DEF_CNT_W     = 20;
  localparam int DEF_NUM_BANDS = 4;

  // One code per band plus the "no band" code 0.
  function automatic int dec_w(input int num_bands);
    return (num_bands < 1) ? 1 : $clog2(num_bands + 1);
  endfunction

  // Slice 0 is the 200 Hz band, slice 3 the 7000 Hz band; limits are periods in clk cycles.
  localparam logic [DEF_NUM_BANDS*DEF_CNT_W-1:0] DEF_BAND_LO =
    {20'd10000, 20'd19000, 20'd90000, 20'd490000};
  localparam logic [DEF_NUM_BANDS*DEF_CNT_W-1:0] DEF_BAND_HI =
    {20'd16000, 20'd21000, 20'd110000, 20'd510000};

endpackage

// File: rtl/ir_period_meter.sv
// Per-channel period measurement: input synchroniser, rising-edge detect,
// saturating cycle counter, arming and loss-of-signal timeout.
module ir_period_meter
  import ir_det_pkg::*;
#(
  parameter int CNT_W       = 20,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blinky,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYC);

  logic             sync_p0;
  logic             sync_p1;
  logic             hist_p2;
  logic             rise;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  assign rise    = sync_p1 & ~hist_p2;
  // An edge in the same cycle as the timeout count means the signal is still alive.
  assign timeout = (cnt == TMO_CNT) & ~rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      hist_p2      <= 1'b0;
      cnt          <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      sync_p0      <= blinky;
      sync_p1      <= sync_p0;
      hist_p2      <= sync_p1;
      period_valid <= rise & armed;
      if (rise) begin
        cnt   <= CNT_W'(1);
        armed <= 1'b1;
        if (armed) period <= cnt;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (timeout) armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ir_freq_classifier.sv
// Multi-channel IR carrier classifier: measures each channel's period, maps it
// onto a programmable band and reports a band code once it has been stable.
module ir_freq_classifier
  import ir_det_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 20,
  parameter int NUM_BANDS   = 4,
  parameter int CONFIRM     = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CHANNELS-1:0]                   blinky,
  input  logic [NUM_BANDS*CNT_W-1:0]            band_lo,
  input  logic [NUM_BANDS*CNT_W-1:0]            band_hi,
  output logic [CHANNELS*CNT_W-1:0]             period,
  output logic [CHANNELS-1:0]                   period_valid,
  output logic [CHANNELS*dec_w(NUM_BANDS)-1:0]  decision,
  output logic [CHANNELS-1:0]                   locked
);

  localparam int DEC_W = dec_w(NUM_BANDS);
  localparam int STK_W = $clog2(CONFIRM + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(CONFIRM);

  // Scanning from the top band down lets the lowest matching index win.
  function automatic logic [DEC_W-1:0] band_code(
    input logic [CNT_W-1:0]           p,
    input logic [NUM_BANDS*CNT_W-1:0] lo,
    input logic [NUM_BANDS*CNT_W-1:0] hi
  );
    logic [DEC_W-1:0] code;
    code = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if ((lo[i*CNT_W +: CNT_W] < p) && (p < hi[i*CNT_W +: CNT_W])) code = DEC_W'(i + 1);
    end
    return code;
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [CNT_W-1:0] per_p1;
    logic             vld_p1;
    logic             tmo_p0;
    logic [DEC_W-1:0] code_p1;
    logic [DEC_W-1:0] cand;
    logic [DEC_W-1:0] dec_p2;
    logic [STK_W-1:0] streak;
    logic [STK_W-1:0] streak_nxt;

    ir_period_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_meter (
      .clk          (clk),
      .rst_n        (rst_n),
      .blinky       (blinky[ch]),
      .period       (per_p1),
      .period_valid (vld_p1),
      .timeout      (tmo_p0)
    );

    // Stage p1: classify the freshly captured period and advance the streak.
    assign code_p1    = band_code(per_p1, band_lo, band_hi);
    assign streak_nxt = (code_p1 != cand)   ? STK_W'(1) :
                        (streak == STK_MAX) ? STK_MAX   : streak + STK_W'(1);

    // Stage p2: commit the decision once the candidate is confirmed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand   <= '0;
        streak <= '0;
        dec_p2 <= '0;
      end else if (tmo_p0) begin
        cand   <= '0;
        streak <= '0;
        dec_p2 <= '0;
      end else if (vld_p1) begin
        cand   <= code_p1;
        streak <= streak_nxt;
        if (streak_nxt == STK_MAX) dec_p2 <= code_p1;
      end
    end

    assign period[ch*CNT_W +: CNT_W]   = per_p1;
    assign period_valid[ch]            = vld_p1;
    assign decision[ch*DEC_W +: DEC_W] = dec_p2;
    assign locked[ch]                  = (dec_p2 != '0);
  end

endmodule
